i2s_data_sched: RTL and testbench

Sequences data movement between the APB data holding registers and the I2S Tx/Rx FIFOs. It sits between the APB slave, the register bank and the two FIFOs.
- Drains the Tx holding register into the Tx FIFO and pre-fetches Rx FIFO words into the Rx holding register.
- Inserts APB wait states (pready low) when a data access cannot complete yet.
- Errors the access out (pslverr) after a bounded wait.

---
 rtl/i2s_data_sched.sv | 150 +++++++++++++++
 tb/tb_i2s_data_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_data_sched.sv
// i2s_data_sched: moves data between the APB holding registers and the I2S
// Tx/Rx FIFOs. It stalls APB data accesses until the holding register is
// serviceable, and ends a stalled access with an error once the wait bound
// is reached.
module i2s_data_sched #(
  parameter int unsigned             ADDR_W  = 8,
  parameter logic [ADDR_W-1:0]       TX_ADDR = 'h04,
  parameter logic [ADDR_W-1:0]       RX_ADDR = 'h08,
  parameter int unsigned             TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              tx_en,
  input  logic              rx_en,
  input  logic              tx_full,
  input  logic              rx_empty,
  output logic              pready,
  output logic              pslverr,
  output logic              hold_wen,
  output logic              hold_ren,
  output logic              tx_wen,
  output logic              rx_ren,
  output logic              rx_cap,
  output logic              tx_occ,
  output logic              rx_occ
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               tx_wen_q, tx_wen_d;
  logic               tx_occ_q, tx_occ_d;
  logic               rx_ren_q, rx_ren_d;
  logic               rx_cap_q, rx_cap_d;
  logic               rx_occ_q, rx_occ_d;
  logic               pend_q, pend_d;

  logic access, tx_acc, rx_acc, tx_ok, rx_ok, timeout_hit;

  assign access      = psel & penable;
  assign tx_acc      = access & pwrite & (paddr == TX_ADDR);
  assign rx_acc      = access & ~pwrite & (paddr == RX_ADDR);
  assign tx_ok       = tx_acc & ~tx_occ_q;
  assign rx_ok       = rx_acc & rx_occ_q;
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  // APB response decode and wait-state FSM next state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pready     = 1'b0;
    pslverr    = 1'b0;
    hold_wen   = 1'b0;
    hold_ren   = 1'b0;

    if (access) begin
      if (tx_ok) begin
        pready   = 1'b1;
        hold_wen = 1'b1;
      end else if (rx_ok) begin
        pready   = 1'b1;
        hold_ren = 1'b1;
      end else if (tx_acc | rx_acc) begin
        if (timeout_hit) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end else begin
        pready = 1'b1;
      end
    end

    // Only a blocked data access can leave pready low during an access cycle.
    case (state_q)
      S_IDLE: begin
        if (access & ~pready) begin
          state_d    = S_WAIT;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (~psel || (access & pready)) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (access) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Tx drain and Rx prefetch engines next state.
  always_comb begin
    tx_wen_d = tx_en & tx_occ_q & ~tx_full & ~tx_wen_q;
    tx_occ_d = tx_occ_q;
    if (hold_wen)      tx_occ_d = 1'b1;
    else if (tx_wen_d) tx_occ_d = 1'b0;

    rx_ren_d = rx_en & ~rx_occ_q & ~rx_empty & ~pend_q;
    pend_d   = rx_ren_d;
    rx_cap_d = pend_q;
    rx_occ_d = rx_occ_q;
    if (pend_q)        rx_occ_d = 1'b1;
    else if (hold_ren) rx_occ_d = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      tx_wen_q   <= 1'b0;
      tx_occ_q   <= 1'b0;
      rx_ren_q   <= 1'b0;
      rx_cap_q   <= 1'b0;
      rx_occ_q   <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tx_wen_q   <= tx_wen_d;
      tx_occ_q   <= tx_occ_d;
      rx_ren_q   <= rx_ren_d;
      rx_cap_q   <= rx_cap_d;
      rx_occ_q   <= rx_occ_d;
      pend_q     <= pend_d;
    end
  end

  assign tx_wen = tx_wen_q;
  assign rx_ren = rx_ren_q;
  assign rx_cap = rx_cap_q;
  assign tx_occ = tx_occ_q;
  assign rx_occ = rx_occ_q;

endmodule

// File: tb/tb_i2s_data_sched.sv
// Testbench for i2s_data_sched: a driver applies APB transfers and FIFO
// status, a reference model predicts every cycle's outputs into a queue,
// and a monitor on the falling edge pops and compares.
module tb_i2s_data_sched;

  localparam int          TIMEOUT = 16;
  localparam logic [7:0]  TX_A    = 8'h04;
  localparam logic [7:0]  RX_A    = 8'h08;

  logic       pclk = 1'b0;
  logic       preset, psel, penable, pwrite;
  logic [7:0] paddr;
  logic       tx_en, rx_en, tx_full, rx_empty;
  logic       pready, pslverr, hold_wen, hold_ren;
  logic       tx_wen, rx_ren, rx_cap, tx_occ, rx_occ;

  i2s_data_sched #(
    .ADDR_W (8),
    .TX_ADDR(TX_A),
    .RX_ADDR(RX_A),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .tx_en   (tx_en),
    .rx_en   (rx_en),
    .tx_full (tx_full),
    .rx_empty(rx_empty),
    .pready  (pready),
    .pslverr (pslverr),
    .hold_wen(hold_wen),
    .hold_ren(hold_ren),
    .tx_wen  (tx_wen),
    .rx_ren  (rx_ren),
    .rx_cap  (rx_cap),
    .tx_occ  (tx_occ),
    .rx_occ  (rx_occ)
  );

  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] exp_q[$];

  // Reference model: holding-register occupancy, in-flight FIFO operations,
  // and the number of access cycles the current transfer has waited.
  bit m_tx_occ, m_tx_push, m_rx_occ, m_rx_pop, m_rx_cap;
  int m_waits;
  bit exp_pready;
  bit rand_env;
  int full_release;
  int n_wen_exp = 0;
  int n_wen_dut = 0;

  task automatic step();
    bit acc, txa, rxa, tx_ok, rx_ok, blocked, tout;
    bit n_push, n_txocc, n_pop, n_cap, n_rxocc;
    int n_waits;
    logic [8:0] e;
    acc     = psel && penable;
    txa     = acc && pwrite && (paddr == TX_A);
    rxa     = acc && !pwrite && (paddr == RX_A);
    tx_ok   = txa && !m_tx_occ;
    rx_ok   = rxa && m_rx_occ;
    blocked = (txa && !tx_ok) || (rxa && !rx_ok);
    tout    = blocked && (m_waits == TIMEOUT - 1);
    exp_pready = acc && (!blocked || tout);
    e = {exp_pready, tout, tx_ok, rx_ok, m_tx_push, m_rx_pop, m_rx_cap,
         m_tx_occ, m_rx_occ};
    exp_q.push_back(e);
    if (m_tx_push) n_wen_exp++;

    n_push  = tx_en && m_tx_occ && !tx_full && !m_tx_push;
    n_txocc = tx_ok ? 1'b1 : (n_push ? 1'b0 : m_tx_occ);
    n_pop   = rx_en && !m_rx_occ && !rx_empty && !m_rx_pop;
    n_cap   = m_rx_pop;
    n_rxocc = m_rx_pop ? 1'b1 : (rx_ok ? 1'b0 : m_rx_occ);
    if (!psel)                n_waits = 0;
    else if (!acc)            n_waits = m_waits;
    else if (blocked && !tout) n_waits = m_waits + 1;
    else                      n_waits = 0;
    if (!preset) begin
      n_push = 0; n_txocc = 0; n_pop = 0; n_cap = 0; n_rxocc = 0; n_waits = 0;
    end

    @(posedge pclk);
    m_tx_push = n_push;
    m_tx_occ  = n_txocc;
    m_rx_pop  = n_pop;
    m_rx_cap  = n_cap;
    m_rx_occ  = n_rxocc;
    m_waits   = n_waits;
    cyc++;
    #1;
    if (full_release > 0) begin
      full_release--;
      if (full_release == 0) tx_full = 1'b0;
    end
    if (rand_env) begin
      tx_en    = ($urandom_range(0, 9) != 0);
      rx_en    = ($urandom_range(0, 9) != 0);
      tx_full  = ($urandom_range(0, 2) == 0);
      rx_empty = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One APB transfer; abort_after >= 0 drops psel after that many waits.
  task automatic apb(input bit wr, input logic [7:0] a, input int abort_after);
    int waits;
    waits   = 0;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    step();
    penable = 1'b1;
    for (int k = 0; k < 4 * TIMEOUT; k++) begin
      step();
      if (exp_pready) break;
      waits++;
      if (abort_after >= 0 && waits >= abort_after) break;
    end
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic do_reset();
    preset = 1'b0;
    step();
    preset = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the oldest prediction.
  always @(negedge pclk) begin
    logic [8:0] got, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {pready, pslverr, hold_wen, hold_ren, tx_wen, rx_ren, rx_cap,
             tx_occ, rx_occ};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL outs cyc=%0d got=%b exp=%b (pready,pslverr,hold_wen,hold_ren,tx_wen,rx_ren,rx_cap,tx_occ,rx_occ)",
                 cyc, got, e);
      end
      if (tx_wen === 1'b1) n_wen_dut++;
    end
  end

  initial begin
    preset   = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = 8'h00;
    tx_en    = 1'b0;
    rx_en    = 1'b0;
    tx_full  = 1'b0;
    rx_empty = 1'b1;
    rand_env = 1'b0;
    full_release = 0;
    m_tx_occ = 0; m_tx_push = 0; m_rx_occ = 0; m_rx_pop = 0; m_rx_cap = 0;
    m_waits  = 0;
    @(posedge pclk);
    #1;

    // Reset state and idle.
    do_reset();
    steps(2);

    // Non-data access completes with zero waits.
    apb(1'b0, 8'h00, -1);
    steps(1);

    // Single Tx write then drain.
    tx_en = 1'b1;
    apb(1'b1, TX_A, -1);
    steps(3);

    // Back-to-back writes with the FIFO full for five cycles.
    tx_full = 1'b1;
    full_release = 5;
    apb(1'b1, TX_A, -1);
    apb(1'b1, TX_A, -1);
    steps(4);

    // Rx prefetch and read.
    rx_en    = 1'b1;
    rx_empty = 1'b0;
    steps(3);
    apb(1'b0, RX_A, -1);
    steps(3);

    // Read timeout with an empty Rx FIFO.
    rx_empty = 1'b1;
    do_reset();
    apb(1'b0, RX_A, -1);
    steps(2);

    // Reset while a write is waiting on an occupied holding register.
    tx_en = 1'b0;
    apb(1'b1, TX_A, -1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = TX_A;
    step();
    penable = 1'b1;
    steps(3);
    preset = 1'b0;
    step();
    preset = 1'b1;
    psel = 1'b0; penable = 1'b0;
    steps(3);

    // Aborted wait, then a full-length wait.
    apb(1'b1, TX_A, -1);
    apb(1'b1, TX_A, 3);
    steps(1);
    apb(1'b1, TX_A, -1);
    tx_en = 1'b1;
    steps(3);

    // Randomized traffic and FIFO conditions.
    rand_env = 1'b1;
    for (int t = 0; t < 300; t++) begin
      int sel;
      logic [7:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 4)      a = TX_A;
      else if (sel < 8) a = RX_A;
      else if (sel < 9) a = 8'h00;
      else              a = 8'($urandom);
      apb($urandom_range(0, 1) == 1, a,
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1);
      steps($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    rand_env = 1'b0;
    steps(3);

    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    checks++;
    if (n_wen_dut != n_wen_exp) begin
      failures++;
      $display("FAIL tx_wen_count got=%0d required=%0d", n_wen_dut, n_wen_exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
